cpu_top: RTL and testbench

Top level of the 32-bit, 5-stage pipelined MIPS-subset processor (IF, ID, EX, MEM, WB). It owns the PC, instruction memory, register file, ALU, data memory, pipeline registers, forwarding and hazard logic. It has no functional I/O beyond clock and reset. Benches preload programs and inspect state through fixed hierarchical names.

---
 rtl/cpu_top.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cpu_top.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_top.sv
// Five-stage pipelined MIPS-subset core (IF, ID, EX, MEM, WB) with EX-stage forwarding,
// a one-cycle load-use stall, beq resolved in EX and j resolved in ID.
package cpu_pkg;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_imm;
        logic       is_beq;
        alu_op_e    alu_op;
        logic [4:0] dst;
    } ctrl_t;
endpackage

module cpu_imem (
    input  logic [7:0]  addr_i,
    output logic [31:0] data_o
);
    // Zero at time 0 so unloaded words decode as no-ops; contents are written from outside.
    logic [31:0] mem [0:255] = '{default: '0};

    assign data_o = mem[addr_i];
endmodule

module cpu_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    logic [31:0] pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            pc_q <= '0;
        else if (redirect_i) pc_q <= target_i;
        else if (!stall_i)   pc_q <= pc_q + 32'd4;
    end

    assign pc_o = pc_q;

    cpu_imem IMEM (.addr_i(pc_q[9:2]), .data_o(instr_o));
endmodule

module cpu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            regs[wa_i] <= wd_i;
        end
    end

    // Same-cycle write-through lets ID see the value WB is retiring.
    always_comb begin
        rd1_o = regs[ra1_i];
        rd2_o = regs[ra2_i];
        if (we_i && wa_i == ra1_i) rd1_o = wd_i;
        if (we_i && wa_i == ra2_i) rd2_o = wd_i;
        if (ra1_i == 5'd0)         rd1_o = '0;
        if (ra2_i == 5'd0)         rd2_o = '0;
    end
endmodule

module cpu_top
    import cpu_pkg::*;
(
    input logic clk,
    input logic rst
);
    logic [31:0] if_pc, if_instr, redirect_pc;
    logic        stall, jump, beq_taken;

    logic [31:0] ifid_instr_q, ifid_pc4_q;
    ctrl_t       idex_ctrl_d, idex_ctrl_q;
    logic [31:0] idex_a_q, idex_b_q, idex_imm_q, idex_pc4_q;
    logic [4:0]  idex_rs_q, idex_rt_q;
    logic        exmem_we_q, exmem_rd_q, exmem_wr_q;
    logic [4:0]  exmem_dst_q;
    logic [31:0] exmem_alu_q, exmem_sd_q;
    logic        memwb_we_q;
    logic [4:0]  memwb_dst_q;
    logic [31:0] memwb_wd_q;

    logic [31:0] dmem_q [0:255];

    // ---------------- IF ----------------
    cpu_fetch IF (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall),
        .redirect_i(beq_taken | jump),
        .target_i  (redirect_pc),
        .pc_o      (if_pc),
        .instr_o   (if_instr)
    );

    // ---------------- ID ----------------
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm, id_a, id_b, id_jtarget;
    logic        id_is_j, load_use;

    assign id_op      = ifid_instr_q[31:26];
    assign id_rs      = ifid_instr_q[25:21];
    assign id_rt      = ifid_instr_q[20:16];
    assign id_imm     = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
    assign id_rd      = id_imm[15:11];
    assign id_funct   = id_imm[5:0];
    assign id_jtarget = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};

    cpu_regfile RF (
        .clk  (clk),
        .rst  (rst),
        .ra1_i(id_rs),
        .ra2_i(id_rt),
        .we_i (memwb_we_q),
        .wa_i (memwb_dst_q),
        .wd_i (memwb_wd_q),
        .rd1_o(id_a),
        .rd2_o(id_b)
    );

    always_comb begin
        idex_ctrl_d = '0;
        id_is_j     = 1'b0;
        case (id_op)
            6'h00: begin
                idex_ctrl_d.reg_write = 1'b1;
                idex_ctrl_d.dst       = id_rd;
                case (id_funct)
                    6'h20:   idex_ctrl_d.alu_op = ALU_ADD;
                    6'h22:   idex_ctrl_d.alu_op = ALU_SUB;
                    6'h24:   idex_ctrl_d.alu_op = ALU_AND;
                    6'h25:   idex_ctrl_d.alu_op = ALU_OR;
                    6'h2A:   idex_ctrl_d.alu_op = ALU_SLT;
                    default: idex_ctrl_d.reg_write = 1'b0;
                endcase
            end
            6'h08: begin
                idex_ctrl_d.reg_write = 1'b1;
                idex_ctrl_d.alu_imm   = 1'b1;
                idex_ctrl_d.dst       = id_rt;
            end
            6'h23: begin
                idex_ctrl_d.reg_write = 1'b1;
                idex_ctrl_d.mem_read  = 1'b1;
                idex_ctrl_d.alu_imm   = 1'b1;
                idex_ctrl_d.dst       = id_rt;
            end
            6'h2B: begin
                idex_ctrl_d.mem_write = 1'b1;
                idex_ctrl_d.alu_imm   = 1'b1;
            end
            6'h04:   idex_ctrl_d.is_beq = 1'b1;
            6'h02:   id_is_j = 1'b1;
            default: ;
        endcase
        // r0 is never a real destination, so it must not forward or write.
        if (idex_ctrl_d.dst == 5'd0) idex_ctrl_d.reg_write = 1'b0;
    end

    assign load_use = idex_ctrl_q.mem_read && idex_ctrl_q.reg_write &&
                      (idex_ctrl_q.dst == id_rs || idex_ctrl_q.dst == id_rt);
    assign jump     = id_is_j && !beq_taken;
    assign stall    = load_use && !jump && !beq_taken;

    // ---------------- EX ----------------
    logic [31:0] ex_a, ex_b, ex_op_b, ex_res, ex_btarget;

    always_comb begin
        ex_a = idex_a_q;
        ex_b = idex_b_q;
        if (memwb_we_q && memwb_dst_q == idex_rs_q) ex_a = memwb_wd_q;
        if (exmem_we_q && exmem_dst_q == idex_rs_q) ex_a = exmem_alu_q;
        if (memwb_we_q && memwb_dst_q == idex_rt_q) ex_b = memwb_wd_q;
        if (exmem_we_q && exmem_dst_q == idex_rt_q) ex_b = exmem_alu_q;
    end

    assign ex_op_b = idex_ctrl_q.alu_imm ? idex_imm_q : ex_b;

    always_comb begin
        case (idex_ctrl_q.alu_op)
            ALU_SUB: ex_res = ex_a - ex_op_b;
            ALU_AND: ex_res = ex_a & ex_op_b;
            ALU_OR:  ex_res = ex_a | ex_op_b;
            ALU_SLT: ex_res = {31'd0, $signed(ex_a) < $signed(ex_op_b)};
            default: ex_res = ex_a + ex_op_b;
        endcase
    end

    assign ex_btarget  = idex_pc4_q + (idex_imm_q << 2);
    assign beq_taken   = idex_ctrl_q.is_beq && (ex_a == ex_b);
    assign redirect_pc = beq_taken ? ex_btarget : id_jtarget;

    // ---------------- MEM ----------------
    logic [31:0] mem_rdata;

    assign mem_rdata = dmem_q[exmem_alu_q[9:2]];

    always_ff @(posedge clk) begin
        if (exmem_wr_q) dmem_q[exmem_alu_q[9:2]] <= exmem_sd_q;
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            idex_ctrl_q  <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_imm_q   <= '0;
            idex_pc4_q   <= '0;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            exmem_we_q   <= 1'b0;
            exmem_rd_q   <= 1'b0;
            exmem_wr_q   <= 1'b0;
            exmem_dst_q  <= '0;
            exmem_alu_q  <= '0;
            exmem_sd_q   <= '0;
            memwb_we_q   <= 1'b0;
            memwb_dst_q  <= '0;
            memwb_wd_q   <= '0;
        end else begin
            if (beq_taken || jump) begin
                ifid_instr_q <= '0;
            end else if (!stall) begin
                ifid_instr_q <= if_instr;
                ifid_pc4_q   <= if_pc + 32'd4;
            end
            idex_ctrl_q <= (beq_taken || stall) ? '0 : idex_ctrl_d;
            idex_a_q    <= id_a;
            idex_b_q    <= id_b;
            idex_imm_q  <= id_imm;
            idex_pc4_q  <= ifid_pc4_q;
            idex_rs_q   <= id_rs;
            idex_rt_q   <= id_rt;
            exmem_we_q  <= idex_ctrl_q.reg_write;
            exmem_rd_q  <= idex_ctrl_q.mem_read;
            exmem_wr_q  <= idex_ctrl_q.mem_write;
            exmem_dst_q <= idex_ctrl_q.dst;
            exmem_alu_q <= ex_res;
            exmem_sd_q  <= ex_b;
            memwb_we_q  <= exmem_we_q;
            memwb_dst_q <= exmem_dst_q;
            memwb_wd_q  <= exmem_rd_q ? mem_rdata : exmem_alu_q;
        end
    end
endmodule

// File: tb/tb_cpu_top.sv
// Directed and randomized programs for cpu_top, checked against an instruction-level interpreter.
module tb_cpu_top;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] prog  [0:255];
    logic [31:0] mregs [0:31];
    logic [31:0] mdmem [0:255];
    int          fn_tab [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};

    cpu_top dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    function automatic logic [31:0] f_r(int rs, int rt, int rd, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction
    function automatic logic [31:0] f_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] f_j(int t);
        return {6'h02, 26'(t)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
    endtask

    // Hold reset across a rising edge, load IMEM, release reset mid-cycle.
    task automatic start_prog();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.IF.IMEM.mem[i] = prog[i];
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Architectural interpreter: runs until a j that targets itself.
    task automatic model_run();
        logic [31:0] pc, pc4, nxt, w, a, b, imm, res, addr;
        logic [5:0]  op, fn;
        logic [4:0]  dst;
        logic        wr;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        pc = 32'h0;
        for (int s = 0; s < 4000; s++) begin
            w   = prog[pc[9:2]];
            op  = w[31:26];
            fn  = w[5:0];
            a   = mregs[w[25:21]];
            b   = mregs[w[20:16]];
            imm = {{16{w[15]}}, w[15:0]};
            pc4 = pc + 32'd4;
            nxt = pc4;
            wr  = 1'b0;
            dst = w[20:16];
            res = 32'h0;
            addr = a + imm;
            if (op == 6'h02 && {pc4[31:28], w[25:0], 2'b00} == pc) break;
            case (op)
                6'h00: begin
                    dst = w[15:11];
                    wr  = 1'b1;
                    case (fn)
                        6'h20:   res = a + b;
                        6'h22:   res = a - b;
                        6'h24:   res = a & b;
                        6'h25:   res = a | b;
                        6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: wr = 1'b0;
                    endcase
                end
                6'h08: begin res = addr; wr = 1'b1; end
                6'h23: begin res = mdmem[addr[9:2]]; wr = 1'b1; end
                6'h2B: mdmem[addr[9:2]] = b;
                6'h04: if (a == b) nxt = pc4 + (imm << 2);
                6'h02: nxt = {pc4[31:28], w[25:0], 2'b00};
                default: ;
            endcase
            if (wr && dst != 5'd0) mregs[dst] = res;
            pc = nxt;
        end
    endtask

    task automatic check_model(input string tag);
        model_run();
        for (int r = 0; r < 32; r++) chk($sformatf("%s_r%0d", tag, r), dut.RF.regs[r], mregs[r]);
    endtask

    initial begin : main
        int halt, kind, rem, lim, rs, rt, rd;
        for (int i = 0; i < 256; i++) mdmem[i] = 32'h0;

        // add chain; first write lands exactly 4 edges after its fetch edge
        clear_prog();
        prog[0] = 32'h20010005; prog[1] = 32'h20020007; prog[2] = 32'h00221820; prog[3] = f_j(3);
        start_prog();
        chk("reset_pc", dut.IF.pc_q, 32'h0);
        repeat (4) @(posedge clk);
        #1 chk("wb_latency_before", dut.RF.regs[1], 32'h0);
        @(posedge clk);
        #1 chk("wb_latency_at", dut.RF.regs[1], 32'd5);
        run(20);
        chk("add_r1", dut.RF.regs[1], 32'd5);
        chk("add_r2", dut.RF.regs[2], 32'd7);
        chk("add_r3", dut.RF.regs[3], 32'd12);

        // sub / slt / and / or
        clear_prog();
        prog[0] = f_i(8, 0, 1, -1);       prog[1] = f_r(0, 1, 2, 32'h22);
        prog[2] = f_r(1, 0, 3, 32'h2A);   prog[3] = f_r(1, 2, 4, 32'h24);
        prog[4] = f_i(8, 0, 6, 32'hF0);   prog[5] = f_r(6, 2, 7, 32'h25);
        prog[6] = f_j(6);
        start_prog(); run(25);
        chk("alu_r1", dut.RF.regs[1], 32'hFFFFFFFF);
        chk("alu_r2", dut.RF.regs[2], 32'd1);
        chk("alu_r3", dut.RF.regs[3], 32'd1);
        chk("alu_r4", dut.RF.regs[4], 32'd1);
        chk("alu_r7", dut.RF.regs[7], 32'hF1);
        check_model("alu");

        // sw/lw with load-use stall: dependent add retires one edge later than without
        clear_prog();
        prog[0] = 32'h2001002A; prog[1] = 32'hAC010008; prog[2] = 32'h8C020008;
        prog[3] = 32'h00421820; prog[4] = f_j(4);
        start_prog();
        repeat (8) @(posedge clk);
        #1 chk("lu_stall_before", dut.RF.regs[3], 32'h0);
        @(posedge clk);
        #1 chk("lu_stall_at", dut.RF.regs[3], 32'd84);
        run(20);
        chk("lw_r2", dut.RF.regs[2], 32'd42);
        chk("lw_r3", dut.RF.regs[3], 32'd84);

        // asynchronous reset mid-run, then full re-execution
        start_prog(); run(10);
        rst = 1'b0;
        #1;
        chk("midrst_pc", dut.IF.pc_q, 32'h0);
        for (int r = 0; r < 32; r++) chk($sformatf("midrst_r%0d", r), dut.RF.regs[r], 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        run(25);
        chk("rerun_r2", dut.RF.regs[2], 32'd42);
        chk("rerun_r3", dut.RF.regs[3], 32'd84);

        // same program with no-ops between
        clear_prog();
        prog[0] = 32'h2001002A; prog[2] = 32'hAC010008; prog[5] = 32'h8C020008;
        prog[7] = 32'h00421820; prog[8] = f_j(8);
        start_prog(); run(30);
        chk("nop_r2", dut.RF.regs[2], 32'd42);
        chk("nop_r3", dut.RF.regs[3], 32'd84);

        // taken beq skips two
        clear_prog();
        prog[0] = 32'h10000002; prog[1] = f_i(8, 0, 4, 1); prog[2] = f_i(8, 0, 5, 1);
        prog[3] = f_i(8, 0, 6, 1); prog[4] = f_j(4);
        start_prog(); run(20);
        chk("beq_t_r4", dut.RF.regs[4], 32'h0);
        chk("beq_t_r5", dut.RF.regs[5], 32'h0);
        chk("beq_t_r6", dut.RF.regs[6], 32'd1);

        // not-taken beq, operand forwarded from the previous instruction
        clear_prog();
        prog[0] = f_i(8, 0, 1, 1); prog[1] = f_i(4, 0, 1, 1); prog[2] = f_i(8, 0, 4, 1);
        prog[3] = f_i(8, 0, 5, 1); prog[4] = f_j(4);
        start_prog(); run(20);
        chk("beq_nt_r4", dut.RF.regs[4], 32'd1);
        chk("beq_nt_r5", dut.RF.regs[5], 32'd1);

        // j skips two
        clear_prog();
        prog[0] = f_j(3); prog[1] = f_i(8, 0, 4, 1); prog[2] = f_i(8, 0, 5, 1);
        prog[3] = f_i(8, 0, 6, 1); prog[4] = f_j(4);
        start_prog(); run(20);
        chk("j_r4", dut.RF.regs[4], 32'h0);
        chk("j_r6", dut.RF.regs[6], 32'd1);

        // r0 writes discarded; unknown opcode / funct change nothing
        clear_prog();
        prog[0] = 32'h20000009; prog[1] = f_r(0, 0, 7, 32'h20); prog[2] = f_i(8, 0, 1, 3);
        prog[3] = 32'hFC2A1234; prog[4] = f_r(1, 1, 8, 32'h21); prog[5] = f_i(9, 1, 9, 5);
        prog[6] = f_j(6);
        start_prog(); run(25);
        chk("r0_zero", dut.RF.regs[0], 32'h0);
        chk("r0_r7", dut.RF.regs[7], 32'h0);
        chk("unk_r8", dut.RF.regs[8], 32'h0);
        chk("unk_r9", dut.RF.regs[9], 32'h0);
        chk("unk_r1", dut.RF.regs[1], 32'd3);

        // random programs over r0..r7 with forward-only control flow
        for (int p = 0; p < 8; p++) begin
            clear_prog();
            for (int k = 0; k < 8; k++) prog[k] = f_i(32'h2B, 0, 0, 4 * k);
            halt = 38;
            for (int idx = 8; idx < halt; idx++) begin
                kind = $urandom_range(0, 9);
                rem  = halt - idx - 1;
                lim  = (rem < 3) ? rem : 3;
                rs   = $urandom_range(0, 7);
                rt   = $urandom_range(0, 7);
                rd   = $urandom_range(0, 7);
                case (kind)
                    0, 1, 2: prog[idx] = f_r(rs, rt, rd, fn_tab[$urandom_range(0, 4)]);
                    3:       prog[idx] = f_i(8, rs, rt, $urandom_range(0, 65535));
                    4:       prog[idx] = f_i(32'h23, 0, rt, 4 * $urandom_range(0, 7));
                    5:       prog[idx] = f_i(32'h2B, 0, rt, 4 * $urandom_range(0, 7));
                    6:       prog[idx] = f_i(4, rs, rt, $urandom_range(0, lim));
                    7:       prog[idx] = f_j(idx + 1 + $urandom_range(0, lim));
                    8:       prog[idx] = ($urandom_range(0, 1) == 1) ? {6'h3F, 26'($urandom)}
                                                                    : f_r(rs, rt, rd, 32'h21);
                    default: prog[idx] = f_i(8, rs, rd, $urandom_range(0, 15));
                endcase
            end
            prog[halt] = f_j(halt);
            start_prog(); run(200);
            check_model($sformatf("rand%0d", p));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
